bcd_subtractor_seq: RTL
=======================

# bcd_subtractor_seq

Sequential multi-digit BCD subtractor: computes A − B on packed BCD operands one decimal digit per clock, least significant digit first, with a rippled decimal borrow. It is the inverse-operation companion to the team's combinational single-digit BCD adder. It feeds the same decimal datapath, so that down-counting and difference results never go through a binary conversion. A start/done handshake lets a controller issue one subtraction at a time.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand and result width is 4*DIGITS
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE or DONE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in a[3:0]
- b  input  4*DIGITS  subtrahend, packed BCD, same packing
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse; diff/borrow/invalid are valid from this cycle on
- diff  output  4*DIGITS  result, packed BCD
- borrow  output  1  final borrow out; 1 means a < b
- invalid  output  1  at least one operand digit was > 9

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1: latch a and b into internal registers, clear the running borrow, the digit index and the invalid accumulator, then go to CALC. start=0: stay.
- CALC, each edge, for digit i (index 0..DIGITS-1):
  - t = a_i − b_i − borrow_run, computed signed at 6 bits.
  - If t < 0: d_i = (t + 10) mod 16 and borrow_run = 1.
  - Otherwise: d_i = t mod 16 and borrow_run = 0.
  - d_i goes into the internal result register.
  - invalid_acc |= (a_i > 9) | (b_i > 9).
- After the edge that processes digit DIGITS-1, go to DONE. On that edge, load diff, borrow and invalid from the internal values.
- DONE lasts one cycle. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation). Otherwise return to IDLE.
- start in CALC is ignored; the latched operands are unaffected by changes on a/b.
- diff, borrow and invalid update only on entry to DONE. They hold the previous result through IDLE and CALC.
- a < b: diff is the ten's complement, a − b + 10^DIGITS, with borrow=1.
- Digits > 9 are not corrected or rejected. The arithmetic above is applied as written and invalid=1 marks the result as meaningless.

## Timing
- Reset values: state IDLE, busy=0, done=0, diff=0, borrow=0, invalid=0. The internal operand, result and counter registers are also cleared.
- Latency: start sampled at edge E0. busy=1 after E0 through E_DIGITS−1. Digits are processed on E1..E_DIGITS. After E_DIGITS: busy=0 and done=1 for exactly one cycle.
- Throughput: one operation per DIGITS+1 cycles with start held high (DONE→CALC directly).
- busy and done are never high together.
- rst=1 mid-CALC aborts the operation. On the next edge all outputs return to their reset values and no done pulse follows.
- rst has priority over start on the same edge.
- DIGITS=1: busy is high for one cycle and done follows.

## Test plan
- DIGITS=4, a=0x0042, b=0x0017, pulse start → done 4 cycles after the start edge, diff=0x0025, borrow=0, invalid=0; busy high for exactly 4 cycles.
- a=0x0017, b=0x0042 → diff=0x9975, borrow=1; a=0x1000, b=0x0001 → diff=0x0999, borrow=0 (borrow ripples through three digits); a=b=0x0000 → diff=0x0000, borrow=0.
- Hold start=1 with a=0x5000, b=0x2500 → done pulses every 5 cycles, each with diff=0x2500. start pulses issued while busy=1 produce no extra done.
- Change a/b while busy, from 0x0042/0x0017 to 0x9999/0x0000 → result is still 0x0025; diff keeps its prior value until done.
- a=0x00A0, b=0x0000 → invalid=1, done still pulses after 4 cycles. A following valid operation clears invalid to 0 at its done.
- Assert rst for one cycle two cycles after start → busy=0, diff=0, borrow=0, invalid=0 on the next edge; no done pulse within 10 cycles. A new start then completes normally.

Source files
------------

// File: rtl/bcd_subtractor_seq.sv
// ============================================================================
// Module   : bcd_subtractor_seq
// Brief    : Multi-digit packed-BCD subtractor, one digit per clock, LSD first,
//            with rippled decimal borrow and start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_subtractor_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow,
    output logic                  invalid
);

    localparam int c_W     = 4 * DIGITS;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [c_W-1:0]      a_q;
    logic [c_W-1:0]      b_q;
    logic [c_W-1:0]      res_q;
    logic [c_IDX_W-1:0]  idx_q;
    logic                brw_q;
    logic                inv_q;

    logic [3:0]          dig_a;
    logic [3:0]          dig_b;
    logic [5:0]          t_w;
    logic                neg_w;
    logic [3:0]          dig_d;
    logic [c_W-1:0]      res_d;
    logic                inv_d;

    // Current digit arithmetic; a negative 6-bit difference folds back by +10.
    always_comb begin
        dig_a = a_q[idx_q*4 +: 4];
        dig_b = b_q[idx_q*4 +: 4];
        t_w   = {2'b00, dig_a} - {2'b00, dig_b} - {5'b00000, brw_q};
        neg_w = t_w[5];
        dig_d = neg_w ? (t_w[3:0] + 4'd10) : t_w[3:0];
        res_d = res_q;
        res_d[idx_q*4 +: 4] = dig_d;
        inv_d = inv_q | (dig_a > 4'd9) | (dig_b > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            inv_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        res_q   <= '0;
                        idx_q   <= '0;
                        brw_q   <= 1'b0;
                        inv_q   <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= S_CALC;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    res_q <= res_d;
                    brw_q <= neg_w;
                    inv_q <= inv_d;
                    if (idx_q == c_LAST) begin
                        idx_q   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= res_d;
                        borrow  <= neg_w;
                        invalid <= inv_d;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
